mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
//  Drives a req/ack data-memory bus and formats store byte lanes.
//  Aligns and extends load data into MEM_Read_Data, which the MEM/WB register samples.
//  Holds mem_stall high until the access completes; the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM.
// PARAMETERS
//  ADDR_W  32  width of dmem_addr; data path fixed at 32 bits
// PORTS
//  clk              in   1       pipeline clock; all state changes on posedge
//  rst              in   1       synchronous, active-high reset
//  EX_MEM_ALUout    in   32      effective address
//  EX_MEM_RD2       in   32      store data (rs2)
//  EX_MEM_MemRead   in   1       load in MEM stage
//  EX_MEM_MemWrite  in   1       store in MEM stage
//  EX_MEM_DMType    in   3       access width/sign (mem_pkg encoding)
//  MEM_Read_Data    out  32      registered, aligned, extended load result
//  mem_stall        out  1       combinational; freeze upstream stages
//  dmem_req         out  1       registered request, held until ack
//  dmem_we          out  1       1 = write
//  dmem_addr        out  ADDR_W  word-aligned address (bits [1:0] = 0)
//  dmem_be          out  4       byte enables
//  dmem_wdata       out  32      lane-replicated store data
//  dmem_rdata       in   32      full read word, valid with ack
//  dmem_ack         in   1       one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state IDLE. MEM_Read_Data, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are all 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - access = MemRead | MemWrite. MemRead takes priority if both are set; that case is treated as a load.
//  - IDLE with access: latch the bus fields, set dmem_req=1 next cycle, go to BUSY.
//  - IDLE without access: stay in IDLE; no request.
//  - BUSY: hold req and all bus fields stable until dmem_ack.
//  - On ack: dmem_req=0. For a load, MEM_Read_Data <= aligned(dmem_rdata). Go to DONE.
//  - DONE: one cycle with stall low; the pipeline advances and MEM/WB samples. Then go to IDLE.
//  - mem_stall = (IDLE & access) | BUSY. It is low in DONE and in idle IDLE.
//  - Minimum latency, ack in the first req cycle: 2 stall cycles. Each extra wait cycle adds 1.
//  - MEM_Read_Data keeps its value across stores and idle cycles; only a completed load updates it.
//  - Store lanes: sb be=1<<a[1:0], wdata={4{b}}; sh be=a[1]?1100:0011, wdata={2{h}}; sw be=1111.
//  - Loads: dmem_be=1111. Extract byte a[1:0] or half a[1], then sign- or zero-extend per DMType.
//  - Misalignment (macro off): a[0] is ignored for halves; a[1:0] is ignored for words.
//  - dmem_ack outside BUSY is ignored.
//  - Reset in BUSY: next edge goes to IDLE with req=0 and the access abandoned. Memory must tolerate a dropped req.
//  - Unknown DMType: treated as word.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - Adds output mem_misalign (1, registered).
//   - Misaligned half (a[0]=1) or word (a[1:0]!=0) in IDLE: no request; go straight to DONE with mem_misalign=1 for that cycle.
//   - MEM_Read_Data is unchanged. Stall = 1 cycle.
//   - mem_misalign resets to 0.
//  Undefined: no port; misaligned addresses are truncated as above.
// STRUCTURE
//  mem_pkg:
//   - DMType codes: dm_word=0, dm_halfword=1, dm_halfword_unsigned=2, dm_byte=3, dm_byte_unsigned=4.
//   - FSM state codes: IDLE=0, BUSY=1, DONE=2.
//  Sub-module mem_load_align (combinational): rdata, a[1:0], DMType -> 32-bit load result.
// TESTING
//  1. sw addr 0x100 data 0xDEADBEEF, ack on the first req cycle:
//     - req for 1 cycle; be=1111, addr=0x100, we=1.
//     - stall 2 cycles, then DONE.
//  2. lb addr 0x103, rdata 0x80xxxxxx, ack after 3 wait cycles:
//     - MEM_Read_Data=0xFFFFFF80; stall 5 cycles.
//     - lbu at the same address gives 0x00000080.
//  3. sh addr 0x202 data 0x1234ABCD:
//     - be=1100, wdata=0xABCDABCD, dmem_addr=0x200.
//     - lhu from 0x202 with rdata 0xABCD0000 gives 0x0000ABCD.
//  4. rst asserted in BUSY before ack:
//     - next edge: req=0, state IDLE, MEM_Read_Data=0.
//     - a later ack pulse causes no update.
//  5. Back-to-back lw then sw:
//     - the second request is issued only after DONE.
//     - the lw result is held through the sw.
//  6. MEM_MISALIGN_TRAP_EN, lw addr 0x101:
//     - no req; mem_misalign=1 for one cycle; stall 1 cycle; MEM_Read_Data unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: access-width codes, FSM states
// and the store byte-lane payload formatter.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    dm_word              = 3'd0,
    dm_halfword          = 3'd1,
    dm_halfword_unsigned = 3'd2,
    dm_byte              = 3'd3,
    dm_byte_unsigned     = 3'd4
  } dm_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } store_lanes_t;

  // Byte enables and lane-replicated data for a store; unknown codes act as word.
  function automatic store_lanes_t store_format(input dm_type_t dm, input logic [1:0] off,
                                                input logic [DATA_W-1:0] data);
    store_lanes_t s;
    case (dm)
      dm_byte, dm_byte_unsigned: begin
        s.be    = 4'b0001 << off;
        s.wdata = {4{data[7:0]}};
      end
      dm_halfword, dm_halfword_unsigned: begin
        s.be    = off[1] ? 4'b1100 : 4'b0011;
        s.wdata = {2{data[15:0]}};
      end
      default: begin
        s.be    = 4'b1111;
        s.wdata = data;
      end
    endcase
    return s;
  endfunction

  function automatic logic is_misaligned(input dm_type_t dm, input logic [1:0] off);
    case (dm)
      dm_byte, dm_byte_unsigned:         return 1'b0;
      dm_halfword, dm_halfword_unsigned: return off[0];
      default:                           return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the read
// word and sign- or zero-extends it; unknown codes pass the full word through.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  dm_type_t          dm,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (dm)
      dm_byte:              result_c = {{24{byte_sel[7]}}, byte_sel};
      dm_byte_unsigned:     result_c = {24'd0, byte_sel};
      dm_halfword:          result_c = {{16{half_sel[15]}}, half_sel};
      dm_halfword_unsigned: result_c = {16'd0, half_sel};
      default:              result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory master with store lane
// formatting and aligned load write-back. Option macro: MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       EX_MEM_ALUout,
  input  logic [31:0]       EX_MEM_RD2,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic [2:0]        EX_MEM_DMType,
  output logic [31:0]       MEM_Read_Data,
  output logic              mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              mem_misalign,
`endif
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  state_t       state;
  logic [1:0]   off_q;
  dm_type_t     dm_q;
  dm_type_t     dm_in;
  logic         access;
  logic         trap_c;
  store_lanes_t lanes_c;
  logic [31:0]  load_c;

  assign dm_in     = dm_type_t'(EX_MEM_DMType);
  assign access    = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign lanes_c   = store_format(dm_in, EX_MEM_ALUout[1:0], EX_MEM_RD2);
  assign mem_stall = ((state == IDLE) & access) | (state == BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(dm_in, EX_MEM_ALUout[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  mem_load_align u_align (
    .rdata    (dmem_rdata),
    .off      (off_q),
    .dm       (dm_q),
    .result_c (load_c)
  );

  // Access sequencer; bus fields are latched in IDLE and held until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      off_q         <= 2'd0;
      dm_q          <= dm_word;
      MEM_Read_Data <= 32'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= 4'd0;
      dmem_wdata    <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access && trap_c) begin
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign <= 1'b1;
`endif
            state <= DONE;
          end else if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ~EX_MEM_MemRead;
            dmem_addr  <= {EX_MEM_ALUout[ADDR_W-1:2], 2'b00};
            dmem_be    <= EX_MEM_MemRead ? 4'b1111 : lanes_c.be;
            dmem_wdata <= lanes_c.wdata;
            off_q      <= EX_MEM_ALUout[1:0];
            dm_q       <= dm_in;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) MEM_Read_Data <= load_c;
            state <= DONE;
          end
        end
        DONE: begin
`ifdef MEM_MISALIGN_TRAP_EN
          mem_misalign <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic model of the bus and load rules.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  dm_type = 3'd0;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .EX_MEM_ALUout   (alu_out),
    .EX_MEM_RD2      (rd2),
    .EX_MEM_MemRead  (mem_read),
    .EX_MEM_MemWrite (mem_write),
    .EX_MEM_DMType   (dm_type),
    .MEM_Read_Data   (read_data),
    .mem_stall       (mem_stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misalign    (mem_misalign),
`endif
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: codes 3/4 byte, 1/2 half, anything else word.
  function automatic logic [31:0] model_load(input logic [2:0] dm, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    if (dm == 3'd3 || dm == 3'd4) begin
      v = (rdata >> ((a % 4) * 8)) & 32'hFF;
      if (dm == 3'd3 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (dm == 3'd1 || dm == 3'd2) begin
      v = (rdata >> ((a & 32'd2) * 8)) & 32'hFFFF;
      if (dm == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] dm, input logic [31:0] a, input logic is_load);
    if (is_load) return 32'hF;
    if (dm == 3'd3 || dm == 3'd4) return 32'd1 << (a % 4);
    if (dm == 3'd1 || dm == 3'd2) return ((a & 32'd2) != 0) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] dm, input logic [31:0] d);
    if (dm == 3'd3 || dm == 3'd4) return (d & 32'hFF) * 32'h0101_0101;
    if (dm == 3'd1 || dm == 3'd2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic go_idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One access from IDLE through DONE; ack arrives on request cycle waits+1.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] dm,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input int waits, input string tag);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    mem_read  = rd;
    mem_write = wr;
    dm_type   = dm;
    alu_out   = a;
    rd2       = d;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check_eq({tag, " req_in_idle"}, dmem_req, 0);
      if (!mem_stall) begin
        done = 1;
        if (rd) exp_rd = model_load(dm, a, rdata);
        check_eq({tag, " req_done"}, dmem_req, 0);
        check_eq({tag, " read_data"}, read_data, exp_rd);
      end else begin
        stalls++;
      end
      if (dmem_req) begin
        reqs++;
        check_eq({tag, " addr"}, dmem_addr, a & ~32'd3);
        check_eq({tag, " we"}, dmem_we, !rd);
        check_eq({tag, " be"}, dmem_be, model_be(dm, a, rd));
        if (!rd) check_eq({tag, " wdata"}, dmem_wdata, model_wdata(dm, d));
        if (reqs == waits + 1) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
    end
    check_eq({tag, " completed"}, done, 1);
    check_eq({tag, " stall_cycles"}, stalls, waits + 2);
    check_eq({tag, " req_cycles"}, reqs, waits + 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset req", dmem_req, 0);
    check_eq("reset we", dmem_we, 0);
    check_eq("reset addr", dmem_addr, 0);
    check_eq("reset be", dmem_be, 0);
    check_eq("reset wdata", dmem_wdata, 0);
    check_eq("reset read_data", read_data, 0);
    check_eq("reset stall", mem_stall, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    go_idle(2);

    do_access(1'b0, 1'b1, 3'd0, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, "sw");
    go_idle(1);
    do_access(1'b1, 1'b0, 3'd3, 32'h103, 32'd0, 32'h8012_3456, 3, "lb");
    check_eq("lb value", read_data, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 32'h8012_3456, 1, "lbu");
    check_eq("lbu value", read_data, 32'h0000_0080);
    do_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'd0, 0, "sh");
    do_access(1'b1, 1'b0, 3'd2, 32'h202, 32'd0, 32'hABCD_0000, 2, "lhu");
    check_eq("lhu value", read_data, 32'h0000_ABCD);

    // Stray ack while idle must not update anything.
    go_idle(1);
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack read_data", read_data, exp_rd);
    check_eq("idle_ack req", dmem_req, 0);

    // Back-to-back lw then sw; lw result must survive the store.
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 3'd0, 32'h400, 32'd0, 32'hCAFE_F00D, 1, "b2b_lw");
    do_access(1'b0, 1'b1, 3'd0, 32'h404, 32'h1111_2222, 32'd0, 0, "b2b_sw");
    check_eq("b2b held", read_data, 32'hCAFE_F00D);

    // Both read and write set behaves as a load.
    do_access(1'b1, 1'b1, 3'd1, 32'h306, 32'h7777_7777, 32'h8001_0002, 0, "rw_both");

    // Reset while BUSY abandons the access.
    mem_read  = 1'b1;
    mem_write = 1'b0;
    dm_type   = 3'd0;
    alu_out   = 32'h500;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_busy req_before", dmem_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_read  = 1'b0;
    exp_rd    = 32'd0;
    @(negedge clk);
    check_eq("rst_busy req", dmem_req, 0);
    check_eq("rst_busy read_data", read_data, 0);
    check_eq("rst_busy stall", mem_stall, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h9999_9999;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_eq("rst_busy late_ack read_data", read_data, 0);
    check_eq("rst_busy late_ack req", dmem_req, 0);
    @(posedge clk);
    #1;

`ifdef MEM_MISALIGN_TRAP_EN
    do_access(1'b1, 1'b0, 3'd0, 32'h600, 32'd0, 32'h2468_ACE0, 0, "pre_trap");
    mem_read = 1'b1;
    dm_type  = 3'd0;
    alu_out  = 32'h101;
    @(negedge clk);
    check_eq("trap stall_idle", mem_stall, 1);
    check_eq("trap req_idle", dmem_req, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("trap stall_done", mem_stall, 0);
    check_eq("trap misalign", mem_misalign, 1);
    check_eq("trap req", dmem_req, 0);
    check_eq("trap read_data", read_data, exp_rd);
    go_idle(1);
    @(negedge clk);
    check_eq("trap misalign_clear", mem_misalign, 0);
    @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  dm;
      logic [31:0] a;
      logic        rd;
      logic        wr;
      int unsigned sel;
      dm  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 4);
      rd  = (sel == 0 || sel == 1 || sel == 4);
      wr  = (sel == 2 || sel == 3 || sel == 4);
`ifdef MEM_MISALIGN_TRAP_EN
      if (dm == 3'd1 || dm == 3'd2) a[0] = 1'b0;
      else if (dm != 3'd3 && dm != 3'd4) a[1:0] = 2'b00;
`endif
      do_access(rd, wr, dm, a, $urandom, $urandom, int'($urandom_range(0, 3)), "rand");
      if ($urandom_range(0, 2) == 0) go_idle(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
